// File: rtl/mipi_rx_pkg.sv
// Definitions shared by the MIPI D-PHY receive path: the tap width and the
// delay-calibration FSM state encoding.
package mipi_rx_pkg;

  localparam int TAP_W = 9;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_SETTLE     = 4'd2,
    ST_CHECK      = 4'd3,
    ST_NEXT       = 4'd4,
    ST_APPLY      = 4'd5,
    ST_WAIT_APPLY = 4'd6,
    ST_DONE       = 4'd7,
    ST_FAIL       = 4'd8
  } cal_state_e;

endpackage

// File: rtl/dphy_calib_run_tracker.sv
// Tracks the current run of passing sweep points and keeps the longest run;
// a tie keeps the earlier run.
module dphy_calib_run_tracker
  import mipi_rx_pkg::*;
#(
  parameter int CNT_W = TAP_W + 1
) (
  input  logic             clk_byte,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic             pass_i,
  input  logic             final_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic [TAP_W-1:0] best_start_o,
  output logic [CNT_W-1:0] best_cnt_o
);

  logic [TAP_W-1:0] run_start_q, run_start_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [TAP_W-1:0] eff_start;
  logic [CNT_W-1:0] eff_cnt;
  logic             close_run;

  always_comb begin
    run_start_d  = run_start_q;
    run_cnt_d    = run_cnt_q;
    best_start_d = best_start_q;
    best_cnt_d   = best_cnt_q;
    eff_start    = run_start_q;
    eff_cnt      = run_cnt_q;
    close_run    = !pass_i || final_i;

    // The current point is folded into the run before any close decision.
    if (pass_i) begin
      if (run_cnt_q == '0) begin
        eff_start = tap_i;
      end
      eff_cnt = run_cnt_q + CNT_W'(1);
    end

    if (clear_i) begin
      run_start_d  = '0;
      run_cnt_d    = '0;
      best_start_d = '0;
      best_cnt_d   = '0;
    end else if (step_i) begin
      if (close_run) begin
        if (eff_cnt > best_cnt_q) begin
          best_start_d = eff_start;
          best_cnt_d   = eff_cnt;
        end
        run_start_d = '0;
        run_cnt_d   = '0;
      end else begin
        run_start_d = eff_start;
        run_cnt_d   = eff_cnt;
      end
    end
  end

  always_ff @(posedge clk_byte or negedge rst_n) begin
    if (!rst_n) begin
      run_start_q  <= '0;
      run_cnt_q    <= '0;
      best_start_q <= '0;
      best_cnt_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_cnt_q    <= run_cnt_d;
      best_start_q <= best_start_d;
      best_cnt_q   <= best_cnt_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_cnt_o   = best_cnt_q;

endmodule

// File: rtl/dphy_delay_calib.sv
// IDELAYE3 tap sweep for one D-PHY lane: finds the widest window in which the
// deskew byte is received cleanly and loads the centre of that window.
module dphy_delay_calib
  import mipi_rx_pkg::*;
#(
  parameter int unsigned TAP_MAX       = 511,
  parameter int unsigned TAP_STEP      = 8,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CHECK_CYCLES  = 64,
  parameter logic [7:0]  PATTERN       = 8'h55
) (
  input  logic             clk_byte,
  input  logic             rst_n,
  input  logic             cal_start,
  input  logic [7:0]       rx_byte,
  output logic             dly_load,
  output logic [TAP_W-1:0] dly_cntvaluein,
  output logic             dly_en_vtc,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] best_tap,
  output logic [TAP_W:0]   eye_width,
  output cal_state_e       cal_state
);

  localparam int SUM_W = TAP_W + 1;
  localparam int MUL_W = 2 * SUM_W;
  localparam logic [SUM_W-1:0] STEP_V = SUM_W'(TAP_STEP);
  localparam logic [SUM_W-1:0] MAX_V  = SUM_W'(TAP_MAX);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] CHECK_LAST  = 16'(CHECK_CYCLES - 1);

  cal_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [15:0]      cyc_q, cyc_d;
  logic             pass_q, pass_d;
  logic             dly_load_q, dly_load_d;
  logic [TAP_W-1:0] cntval_q, cntval_d;
  logic             en_vtc_q, en_vtc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [TAP_W-1:0] best_tap_q, best_tap_d;
  logic [SUM_W-1:0] eye_q, eye_d;

  logic             trk_clear, trk_step, trk_final;
  logic [TAP_W-1:0] best_start;
  logic [SUM_W-1:0] best_cnt;

  logic [SUM_W-1:0] tap_next;
  logic             sweep_more;
  logic             sample_ok;
  logic [MUL_W-1:0] half_span;
  logic [TAP_W-1:0] apply_tap;
  logic [SUM_W-1:0] apply_eye;

  // One extra bit on the sum so tap + TAP_STEP can never wrap.
  assign tap_next   = {1'b0, tap_q} + STEP_V;
  assign sweep_more = (tap_next <= MAX_V);
  assign sample_ok  = (rx_byte == PATTERN) || (rx_byte == ~PATTERN);

  assign half_span = ((MUL_W'(best_cnt) - MUL_W'(1)) * MUL_W'(TAP_STEP)) >> 1;
  assign apply_tap = TAP_W'(MUL_W'(best_start) + half_span);
  assign apply_eye = SUM_W'(MUL_W'(best_cnt) * MUL_W'(TAP_STEP));

  dphy_calib_run_tracker #(
    .CNT_W(SUM_W)
  ) u_tracker (
    .clk_byte     (clk_byte),
    .rst_n        (rst_n),
    .clear_i      (trk_clear),
    .step_i       (trk_step),
    .pass_i       (pass_q),
    .final_i      (trk_final),
    .tap_i        (tap_q),
    .best_start_o (best_start),
    .best_cnt_o   (best_cnt)
  );

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    cyc_d      = cyc_q;
    pass_d     = pass_q;
    cntval_d   = cntval_q;
    best_tap_d = best_tap_q;
    eye_d      = eye_q;
    dly_load_d = 1'b0;
    trk_clear  = 1'b0;
    trk_step   = 1'b0;
    trk_final  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (cal_start) begin
          state_d   = ST_LOAD;
          tap_d     = '0;
          cyc_d     = '0;
          trk_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        cyc_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          cyc_d   = '0;
          pass_d  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      ST_CHECK: begin
        pass_d = pass_q & sample_ok;
        if (cyc_q == CHECK_LAST) begin
          cyc_d   = '0;
          state_d = ST_NEXT;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      ST_NEXT: begin
        trk_step = 1'b1;
        if (sweep_more) begin
          tap_d   = tap_next[TAP_W-1:0];
          state_d = ST_LOAD;
        end else begin
          trk_final = 1'b1;
          state_d   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        cyc_d = '0;
        if (best_cnt == '0) begin
          best_tap_d = '0;
          eye_d      = '0;
          state_d    = ST_FAIL;
        end else begin
          best_tap_d = apply_tap;
          eye_d      = apply_eye;
          cntval_d   = apply_tap;
          dly_load_d = 1'b1;
          state_d    = ST_WAIT_APPLY;
        end
      end
      ST_WAIT_APPLY: begin
        if (cyc_q == SETTLE_LAST) begin
          cyc_d   = '0;
          state_d = ST_DONE;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // LOAD always lasts one cycle, so the strobe registered on entry is one cycle wide.
    if (state_d == ST_LOAD) begin
      dly_load_d = 1'b1;
      cntval_d   = tap_d;
    end

    busy_d   = !(state_d inside {ST_IDLE, ST_DONE, ST_FAIL});
    en_vtc_d = !busy_d;
    done_d   = (state_d == ST_DONE);
    fail_d   = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_byte or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tap_q      <= '0;
      cyc_q      <= '0;
      pass_q     <= 1'b0;
      dly_load_q <= 1'b0;
      cntval_q   <= '0;
      en_vtc_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      best_tap_q <= '0;
      eye_q      <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      cyc_q      <= cyc_d;
      pass_q     <= pass_d;
      dly_load_q <= dly_load_d;
      cntval_q   <= cntval_d;
      en_vtc_q   <= en_vtc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      best_tap_q <= best_tap_d;
      eye_q      <= eye_d;
    end
  end

  assign dly_load       = dly_load_q;
  assign dly_cntvaluein = cntval_q;
  assign dly_en_vtc     = en_vtc_q;
  assign cal_busy       = busy_q;
  assign cal_done       = done_q;
  assign cal_fail       = fail_q;
  assign best_tap       = best_tap_q;
  assign eye_width      = eye_q;
  assign cal_state      = state_q;

endmodule

// File: tb/tb_dphy_delay_calib.sv
// Bench for dphy_delay_calib: a lane model returns clean or corrupted bytes
// depending on the loaded tap, and a sweep model predicts every load and result.
module tb_dphy_delay_calib;
  import mipi_rx_pkg::*;

  localparam int TAP_MAX   = 511;
  localparam int TAP_STEP  = 8;
  localparam int SETTLE    = 8;
  localparam int CHECK     = 64;
  localparam logic [7:0] PAT = 8'h55;
  localparam int PT_CYCLES = 1 + SETTLE + CHECK + 1;

  logic       clk_byte;
  logic       rst_n;
  logic       cal_start;
  logic [7:0] rx_byte;
  logic       dly_load;
  logic [8:0] dly_cntvaluein;
  logic       dly_en_vtc;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  logic [8:0] best_tap;
  logic [9:0] eye_width;
  cal_state_e cal_state;

  dphy_delay_calib #(
    .TAP_MAX(TAP_MAX), .TAP_STEP(TAP_STEP), .SETTLE_CYCLES(SETTLE),
    .CHECK_CYCLES(CHECK), .PATTERN(PAT)
  ) dut (
    .clk_byte(clk_byte), .rst_n(rst_n), .cal_start(cal_start), .rx_byte(rx_byte),
    .dly_load(dly_load), .dly_cntvaluein(dly_cntvaluein), .dly_en_vtc(dly_en_vtc),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail),
    .best_tap(best_tap), .eye_width(eye_width), .cal_state(cal_state)
  );

  // clock / reset
  initial clk_byte = 1'b0;
  always #5 clk_byte = ~clk_byte;

  bit         pass_map [0:511];
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [8:0] exp_q[$];
  int         load_cnt = 0;
  int         last_load_cyc = 0;
  int         cyc_cnt = 0;
  int         exp_npts = 0;
  logic [8:0] cur_tap = '0;
  int         garbage_left = 0;
  bit         prev_load = 1'b0;
  int         m_best, m_eye, m_npts, m_last;
  bit         m_ok;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] bad_byte();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == PAT || b == ~PAT) b = 8'($urandom);
    return b;
  endfunction

  // Lane model plus per-cycle compare: corrupt bytes for the load cycle and the
  // whole settle time, then clean/dirty data according to the loaded tap.
  always @(negedge clk_byte) begin
    cyc_cnt++;
    if (!rst_n) begin
      prev_load    = 1'b0;
      garbage_left = 0;
    end else begin
      check("vtc_low_iff_busy", int'(dly_en_vtc), int'(!cal_busy));
      if (cal_busy) check("done_fail_low_while_busy", int'({cal_done, cal_fail}), 0);
      if (dly_load) begin
        check("load_one_cycle", int'(prev_load), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL load_unexpected: got load of tap %0d, expected no load", dly_cntvaluein);
        end else begin
          check("load_value", int'(dly_cntvaluein), int'(exp_q.pop_front()));
        end
        if (load_cnt >= 1 && load_cnt < exp_npts)
          check("load_spacing", cyc_cnt - last_load_cyc, PT_CYCLES);
        load_cnt++;
        last_load_cyc = cyc_cnt;
        cur_tap       = dly_cntvaluein;
        garbage_left  = SETTLE + 1;
      end
      prev_load = dly_load;
    end
    if (garbage_left > 0) begin
      rx_byte = bad_byte();
      garbage_left--;
    end else if (pass_map[cur_tap]) begin
      rx_byte = ($urandom_range(0, 1) == 1) ? PAT : ~PAT;
    end else begin
      rx_byte = ($urandom_range(0, 1) == 1) ? bad_byte() : PAT;
    end
  end

  // Sweep model: list the maximal runs of passing points, keep the first longest.
  task automatic run_model();
    int run_len, run_at, b_len, b_at;
    run_len = 0; run_at = 0; b_len = 0; b_at = 0; m_npts = 0; m_last = 0;
    for (int t = 0; t <= TAP_MAX; t += TAP_STEP) begin
      m_npts++;
      m_last = t;
      if (pass_map[t]) begin
        if (run_len == 0) run_at = t;
        run_len++;
      end
      if (!pass_map[t] || t + TAP_STEP > TAP_MAX) begin
        if (run_len > b_len) begin
          b_len = run_len;
          b_at  = run_at;
        end
        run_len = 0;
      end
    end
    m_ok   = (b_len > 0);
    m_best = m_ok ? b_at + ((b_len - 1) * TAP_STEP) / 2 : 0;
    m_eye  = b_len * TAP_STEP;
  endtask

  task automatic clear_map();
    for (int t = 0; t < 512; t++) pass_map[t] = 1'b0;
  endtask

  task automatic set_window(input int lo, input int hi);
    for (int t = lo; t <= hi && t < 512; t++) pass_map[t] = 1'b1;
  endtask

  // driver tasks
  task automatic pulse_start();
    @(negedge clk_byte);
    cal_start = 1'b1;
    @(negedge clk_byte);
    cal_start = 1'b0;
  endtask

  task automatic begin_case();
    run_model();
    exp_q.delete();
    for (int t = 0; t <= TAP_MAX; t += TAP_STEP) exp_q.push_back(9'(t));
    if (m_ok) exp_q.push_back(9'(m_best));
    exp_npts = m_npts;
    load_cnt = 0;
    pulse_start();
    check("busy_after_start", int'(cal_busy), 1);
  endtask

  task automatic end_case();
    int waited;
    waited = 0;
    while (!(cal_done || cal_fail) && waited < PT_CYCLES * (m_npts + 2) + 100) begin
      @(negedge clk_byte);
      waited++;
    end
    check("run_finished", int'(cal_done | cal_fail), 1);
    check("cal_done", int'(cal_done), int'(m_ok));
    check("cal_fail", int'(cal_fail), int'(!m_ok));
    check("best_tap", int'(best_tap), m_best);
    check("eye_width", int'(eye_width), m_eye);
    check("busy_at_end", int'(cal_busy), 0);
    check("en_vtc_at_end", int'(dly_en_vtc), 1);
    check("loads_left", exp_q.size(), 0);
    check("load_count", load_cnt, m_npts + (m_ok ? 1 : 0));
    if (!m_ok) check("fail_keeps_cntval", int'(dly_cntvaluein), m_last);
    repeat (5) @(negedge clk_byte);
    check("status_sticky", int'({cal_done, cal_fail}), int'({m_ok, !m_ok}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dly_load"}, int'(dly_load), 0);
    check({tag, "_cntval"}, int'(dly_cntvaluein), 0);
    check({tag, "_en_vtc"}, int'(dly_en_vtc), 1);
    check({tag, "_busy"}, int'(cal_busy), 0);
    check({tag, "_done"}, int'(cal_done), 0);
    check({tag, "_fail"}, int'(cal_fail), 0);
    check({tag, "_best_tap"}, int'(best_tap), 0);
    check({tag, "_eye"}, int'(eye_width), 0);
    check({tag, "_state"}, int'(cal_state), int'(ST_IDLE));
  endtask

  initial begin
    #900000;
    n_fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    bit found;
    int mode, lo, hi;
    rst_n = 1'b0;
    cal_start = 1'b0;
    rx_byte = 8'h00;
    clear_map();
    repeat (3) @(negedge clk_byte);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk_byte);
    check_reset_outputs("idle");

    // single wide window, centre of 120..376
    clear_map(); set_window(120, 376);
    begin_case(); end_case();
    check("w1_model_best", m_best, 248);
    check("w1_best_lit", int'(best_tap), 248);
    check("w1_eye_lit", int'(eye_width), 264);

    // nothing passes
    clear_map();
    begin_case(); end_case();
    check("none_fail_lit", int'(cal_fail), 1);
    check("none_best_lit", int'(best_tap), 0);
    check("none_eye_lit", int'(eye_width), 0);

    // equal-length windows: the earlier one wins
    clear_map(); set_window(0, 56); set_window(400, 456);
    begin_case(); end_case();
    check("tie_model_best", m_best, 28);
    check("tie_best_lit", int'(best_tap), 28);

    // window still open when the sweep ends; cal_start during SETTLE and CHECK ignored
    clear_map(); set_window(480, 504);
    begin_case();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk_byte);
      found = (load_cnt >= 3);
    end
    check("reached_third_load", int'(found), 1);
    repeat (2) @(negedge clk_byte);
    pulse_start();
    repeat (30) @(negedge clk_byte);
    pulse_start();
    end_case();
    check("open_best_lit", int'(best_tap), 492);
    check("open_eye_lit", int'(eye_width), 32);
    check("total_loads_lit", load_cnt, 65);

    // asynchronous reset in the middle of CHECK at tap 200, then a clean restart
    clear_map(); set_window(120, 376);
    begin_case();
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk_byte);
      found = dly_load && (dly_cntvaluein == 9'd200);
    end
    check("reached_tap_200", int'(found), 1);
    repeat (20) @(negedge clk_byte);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk_byte);
    rst_n = 1'b1;
    begin_case(); end_case();
    check("restart_best_lit", int'(best_tap), 248);

    // randomized eyes
    for (int it = 0; it < 4; it++) begin
      clear_map();
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        for (int t = 0; t <= TAP_MAX; t += TAP_STEP) pass_map[t] = ($urandom_range(0, 3) != 0);
      end else begin
        for (int w = 0; w < mode; w++) begin
          lo = TAP_STEP * $urandom_range(0, 63);
          hi = lo + TAP_STEP * $urandom_range(0, 20);
          set_window(lo, hi);
        end
      end
      begin_case(); end_case();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dphy_delay_calib.md
DPHY_DELAY_CALIB -- requirements
Module: dphy_delay_calib

Interface
REQ-001 SHALL have parameter TAP_MAX, default 511, meaning the highest IDELAYE3 tap count swept.
REQ-002 SHALL have parameter TAP_STEP, default 8, meaning the tap increment per sweep point.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, meaning the number of clk_byte cycles waited after each tap load before checking.
REQ-004 SHALL have parameter CHECK_CYCLES, default 64, meaning the number of bytes checked per tap.
REQ-005 SHALL have parameter PATTERN, default 8'h55, meaning the deskew byte (PATTERN or ~PATTERN both pass).
REQ-006 SHALL have port clk_byte, input, 1 bit: the single clock, the byte clock (CLKDIV domain of the ISERDESE3).
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port cal_start, input, 1 bit: single-cycle pulse that starts calibration.
REQ-009 SHALL have port rx_byte, input, 8 bits: deserialized lane byte from the ISERDESE3.
REQ-010 SHALL have port dly_load, output, 1 bit: IDELAYE3 LOAD strobe.
REQ-011 SHALL have port dly_cntvaluein, output, 9 bits: IDELAYE3 CNTVALUEIN.
REQ-012 SHALL have port dly_en_vtc, output, 1 bit: IDELAYE3 EN_VTC.
REQ-013 SHALL have port cal_busy, output, 1 bit: high while calibration runs.
REQ-014 SHALL have port cal_done, output, 1 bit: sticky high after a successful calibration.
REQ-015 SHALL have port cal_fail, output, 1 bit: sticky high after a failed calibration.
REQ-016 SHALL have port best_tap, output, 9 bits: the tap finally loaded.
REQ-017 SHALL have port eye_width, output, 10 bits: width of the longest passing run, in taps.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SETTLE, CHECK, NEXT, APPLY, WAIT_APPLY, DONE, FAIL.
REQ-019 SHALL move IDLE/DONE/FAIL->LOAD on cal_start, with tap=0, clearing cal_done, cal_fail and the run trackers; cal_start SHALL be ignored in every other state.
REQ-020 SHALL, in LOAD, assert dly_load for exactly one cycle with dly_cntvaluein=tap, then go to SETTLE.
REQ-021 SHALL, in SETTLE, count SETTLE_CYCLES cycles, then go to CHECK.
REQ-022 SHALL, in CHECK, sample rx_byte for CHECK_CYCLES cycles; the point passes only if every sample equals PATTERN or ~PATTERN.
REQ-023 SHALL, in NEXT, update the run trackers as follows:
- pass: if run_cnt==0 then run_start=tap; run_cnt++.
- fail: close the run.
- when a run closes, it replaces the best run only if its run_cnt is strictly greater (ties keep the earliest run).
REQ-024 SHALL, from NEXT, set tap+=TAP_STEP and go to LOAD if tap+TAP_STEP<=TAP_MAX; otherwise close any open run and go to APPLY.
REQ-025 SHALL, in APPLY, go to FAIL if the best run_cnt==0; otherwise it SHALL:
- set best_tap = best_start + (((best_cnt-1)*TAP_STEP)>>1);
- set eye_width = best_cnt*TAP_STEP;
- pulse dly_load with dly_cntvaluein=best_tap;
- go to WAIT_APPLY.
REQ-026 SHALL, in WAIT_APPLY, wait SETTLE_CYCLES cycles, then enter DONE.
REQ-027 SHALL drive dly_en_vtc low in all states except IDLE, DONE and FAIL.
REQ-028 SHALL drive cal_busy high exactly when the state is outside IDLE/DONE/FAIL.
REQ-029 SHALL use arithmetic wide enough that tap+TAP_STEP never wraps; the sweep SHALL terminate at or below TAP_MAX.
REQ-030 SHALL, in FAIL, keep best_tap=0 and eye_width=0 and leave dly_cntvaluein at its last value.

Reset
REQ-031 SHALL make rst_n low, at any time including mid-sweep, force the following asynchronously:
- state: IDLE;
- dly_load: 0;
- dly_cntvaluein: 0;
- dly_en_vtc: 1;
- cal_busy, cal_done, cal_fail: 0;
- best_tap: 0;
- eye_width: 0;
- all counters and trackers: 0.
REQ-032 SHALL register every output, with no combinational path from rx_byte or cal_start to any output.

Structure
REQ-033 SHALL place the FSM state enumeration and the 9-bit tap width constant in shared package mipi_rx_pkg.
REQ-034 SHALL contain one sub-module, dphy_calib_run_tracker, holding run_start/run_cnt/best_start/best_cnt and the replace-if-longer rule.

Verification
REQ-035 SHALL verify with a bench model where the tap passes for taps 120..376 (TAP_STEP=8): after the sweep, cal_done=1, eye_width=264 and best_tap=248, with a final LOAD of 248.
REQ-036 SHALL verify that when no tap passes, cal_fail=1, cal_done=0, best_tap=0 and eye_width=0.
REQ-037 SHALL verify two windows, 0..56 and 400..456 (equal length 8 points each): best_tap=28, because the earliest run wins the tie.
REQ-038 SHALL verify a window 480..504 that is still open at sweep end: it closes at APPLY, giving best_tap=492 and eye_width=32.
REQ-039 SHALL verify that rst_n pulsed low during CHECK at tap 200 gives all outputs at reset values within the same cycle, and that a subsequent cal_start restarts from tap 0.
REQ-040 SHALL verify that cal_start pulsed during SETTLE has no effect: the number of LOAD pulses equals floor(TAP_MAX/TAP_STEP)+2 (64 sweep points plus 1 final LOAD = 65 for the defaults).
